// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory responder and its lane-strobe helper
package mem_pkg;
   localparam int LAT_W = 4;
   typedef enum logic [2:0] {
      MEM_W_BYTE = 3'd0,
      MEM_W_HALF = 3'd1,
      MEM_W_WORD = 3'd2
   } mem_width_e;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_WAIT,
      ST_WR_WAIT,
      ST_RD_RESP,
      ST_WR_ACK
   } mem_state_e;
endpackage

// File: rtl/mem_wstrb.sv
// mem_wstrb: byte-lane strobe and lane-replicated write data for a little-endian word bus
// Ports: i_addr low address bits, i_width access width (0 byte, 1 half, 2 word),
//        i_data LSB-justified write data, o_strb lane enables, o_data lane data, o_fault bad access.
// Build macro MEM_ALIGN_CHECK_EN: flag misaligned halves/words and widths above 2; faulting
// accesses get an empty strobe. Without it, low bits below the access size are ignored and
// invalid widths act as word.
module mem_wstrb import mem_pkg::*; (
   input  logic [1:0]  i_addr,
   input  logic [2:0]  i_width,
   input  logic [31:0] i_data,
   output logic [3:0]  o_strb,
   output logic [31:0] o_data,
   output logic        o_fault
);
   logic w_byte, w_half;
   logic [3:0] w_strb;
   always_comb begin
      w_byte = i_width == MEM_W_BYTE;
      w_half = i_width == MEM_W_HALF;
      w_strb = w_byte ? 4'b0001 << i_addr : w_half ? (i_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      o_data = w_byte ? {4{i_data[7:0]}} : w_half ? {2{i_data[15:0]}} : i_data;
`ifdef MEM_ALIGN_CHECK_EN
      o_fault = (w_half & i_addr[0]) | (i_width == MEM_W_WORD && i_addr != 2'b00) | (i_width > 3'd2);
`else
      o_fault = 1'b0;
`endif
      o_strb = o_fault ? 4'b0000 : w_strb;
   end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-port word RAM on the core's valid/ready bus with fixed response latency
// Ports: i_clk clock, i_rst sync active-high reset, i_addr byte address, i_data write data,
//        i_wr_valid write request, o_wr_ready write-commit pulse, i_wr_width access width,
//        o_data read word, o_rd_valid read-data pulse, i_rd_ready read request/accept,
//        o_fault faulting-write flag alongside o_wr_ready.
// Build macro MEM_ALIGN_CHECK_EN enables alignment/width faults (see mem_wstrb).
module mem_responder import mem_pkg::*; #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_data,
   input  logic        i_wr_valid,
   output logic        o_wr_ready,
   input  logic [2:0]  i_wr_width,
   output logic [31:0] o_data,
   output logic        o_rd_valid,
   input  logic        i_rd_ready,
   output logic        o_fault
);
   localparam int IDX_W = $clog2(DEPTH);
   mem_state_e       r_state;
   logic [LAT_W-1:0] r_cnt;
   logic [IDX_W+1:0] r_addr;
   logic [31:0]      r_data;
   logic [2:0]       r_width;
   logic [31:0]      r_mem [DEPTH];
   logic             w_idle, w_last, w_we, w_fault, w_unused;
   logic [IDX_W+1:0] w_addr;
   logic [31:0]      w_data, w_lane;
   logic [2:0]       w_width;
   logic [3:0]       w_strb;
   logic [IDX_W-1:0] w_idx;
   // In IDLE the live request is used directly so LATENCY=0 can respond on the next cycle
   assign w_idle   = r_state == ST_IDLE;
   assign w_addr   = w_idle ? i_addr[IDX_W+1:0] : r_addr;
   assign w_data   = w_idle ? i_data : r_data;
   assign w_width  = w_idle ? i_wr_width : r_width;
   assign w_idx    = w_addr[IDX_W+1:2];
   assign w_last   = w_idle ? (LATENCY == 0) : (r_cnt == LAT_W'(1));
   assign w_we     = !i_rst && (w_idle ? (i_wr_valid && LATENCY == 0) : (r_state == ST_WR_WAIT && w_last));
   assign w_unused = &{1'b0, i_addr[31:IDX_W+2]};
   mem_wstrb u_wstrb (
      .i_addr  (w_addr[1:0]),
      .i_width (w_width),
      .i_data  (w_data),
      .o_strb  (w_strb),
      .o_data  (w_lane),
      .o_fault (w_fault)
   );
   always_ff @(posedge i_clk) begin
      if (w_idle) begin
         r_addr  <= w_addr;
         r_data  <= w_data;
         r_width <= w_width;
      end
   end
   always_ff @(posedge i_clk) begin
      for (int j = 0; j < 4; j++)
         if (w_we && w_strb[j]) r_mem[w_idx][8*j+:8] <= w_lane[8*j+:8];
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         o_wr_ready <= 1'b0;
         o_rd_valid <= 1'b0;
         o_data     <= '0;
         o_fault    <= 1'b0;
      end else begin
         o_wr_ready <= 1'b0;
         o_rd_valid <= 1'b0;
         o_fault    <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_cnt <= LAT_W'(LATENCY);
               if (i_wr_valid) begin
                  r_state    <= w_last ? ST_WR_ACK : ST_WR_WAIT;
                  o_wr_ready <= w_last;
                  o_fault    <= w_last & w_fault;
               end else if (i_rd_ready) begin
                  r_state    <= w_last ? ST_RD_RESP : ST_RD_WAIT;
                  o_rd_valid <= w_last;
                  if (w_last) o_data <= r_mem[w_idx];
               end
            end
            ST_WR_WAIT: begin
               r_cnt <= r_cnt - LAT_W'(1);
               if (w_last) begin
                  r_state    <= ST_WR_ACK;
                  o_wr_ready <= 1'b1;
                  o_fault    <= w_fault;
               end
            end
            ST_RD_WAIT: begin
               if (!i_rd_ready) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt - LAT_W'(1);
                  if (w_last) begin
                     r_state    <= ST_RD_RESP;
                     o_rd_valid <= 1'b1;
                     o_data     <= r_mem[w_idx];
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule
